ring_freq_counter: RTL
======================

// Module: ring_freq_counter
// PURPOSE
//  Gated frequency counter that measures ring-oscillator (pre-divided) outputs.
//  Counts rising edges on one of NUM_CH async inputs over a fixed window of GATE_CYCLES clk cycles.
//  Presents the result as a full word and as a byte-selectable 8-bit read port for uo_out muxing.
//  Sits directly downstream of the ring-oscillator/adder array in the tt_um top.
// PARAMETERS
//  NUM_CH        4     number of ring inputs (>=2)
//  CNT_W         16    result width; multiple of 8, >=8
//  GATE_CYCLES   1024  measurement window length in clk cycles (>=1)
//  SETTLE_CYCLES 4     cycles after start before gating opens; flushes synchronizer (>=2)
// PORTS
//  clk       in   1                   system clock
//  rst       in   1                   synchronous, active-high reset
//  ena       in   1                   0 = freeze FSM and all counters; start ignored
//  start     in   1                   level-sampled measurement request
//  ch_sel    in   $clog2(NUM_CH)      channel to measure; latched when start is accepted
//  ring_in   in   NUM_CH              async ring outputs; each must be < clk/2
//  byte_sel  in   max(1,$clog2(CNT_W/8))  byte of count driven on dout; 0 = LSB
//  dout      out  8                   count[8*byte_sel +: 8]; 0 if byte_sel is out of range
//  count     out  CNT_W               last completed result
//  busy      out  1                   1 in SETTLE or MEASURE
//  done      out  1                   1 in DONE (result valid)
//  overflow  out  1                   last result saturated
// BEHAVIOUR
//  Reset: state=IDLE; count, accumulator, timers, sync flops, overflow, busy, done, dout all 0.
//  Sync: every ring_in bit uses a 2-FF synchronizer, clocked always, including when ena=0.
//   edge = s2[ch] & ~s3[ch], where s3 is a per-channel delay of s2, updated every cycle.
//  FSM: IDLE, SETTLE, MEASURE, DONE. All transitions are gated by ena=1.
//   IDLE/DONE: start=1 at edge T accepts the request.
//     Latch ch_sel, clear the accumulator and timer.
//     Enter SETTLE at T+1; busy=1 and done=0 from T+1.
//   SETTLE: lasts exactly SETTLE_CYCLES cycles, then MEASURE.
//   MEASURE: lasts exactly GATE_CYCLES cycles; the accumulator +1 on each cycle with edge=1.
//     At the end, copy the accumulator to count, set overflow, enter DONE.
//     done=1 from T+1+SETTLE_CYCLES+GATE_CYCLES.
//   DONE: holds count and done until the next accepted start (no return to IDLE).
//  start while busy: ignored, no queueing; ch_sel changes while busy have no effect.
//  Saturation: the accumulator sticks at 2^CNT_W-1. overflow=1 if an increment is attempted at max.
//  count/overflow change only on MEASURE->DONE; they hold the prior result while busy.
//  ena=0: state, timers and accumulator hold; edges during a freeze are not counted.
//   Resuming continues the window.
//  rst mid-operation: immediate return to reset values next cycle; the result is discarded.
//  Timer width is $clog2(max(GATE_CYCLES,SETTLE_CYCLES)+1). No wrap: the terminal compare ends the phase.
//  dout is combinational from count and byte_sel.
// TESTING
//  1 ring_in[0]: square wave, period 8 clk. ch_sel=0, start 1 cycle.
//    -> busy 1028 cycles; done=1; count=128+/-1; overflow=0.
//  2 ring_in[2] stuck at 1; ring_in[0] toggles at period 4. ch_sel=2.
//    -> count=0 (channel isolation).
//  3 CNT_W=8, GATE_CYCLES=1024; ring_in[1] period 2.
//    -> count=255 (0xFF); overflow=1.
//  4 start held high across a run, ch_sel changed mid-MEASURE.
//    -> exactly one measurement on the latched channel.
//    -> with start still high in DONE, a new run starts the next cycle.
//  5 rst pulsed at MEASURE cycle 500. -> next cycle all outputs 0; a new start gives a full-length run.
//  6 Force a result of 0x1234. -> dout=0x34 at byte_sel=0, 0x12 at byte_sel=1.
//    -> ena=0 for 100 cycles mid-window lengthens busy by 100; result unchanged vs. baseline.

Source files
------------

// File: rtl/ring_freq_counter.sv
// Gated frequency counter: counts synchronized rising edges on one selected ring
// input over a fixed window and holds the last result for word or byte readout.
module ring_freq_counter #(
  parameter  int NUM_CH        = 4,
  parameter  int CNT_W         = 16,
  parameter  int GATE_CYCLES   = 1024,
  parameter  int SETTLE_CYCLES = 4,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int NBYTES        = CNT_W / 8,
  localparam int BSEL_W        = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [NUM_CH-1:0] ring_in,
  input  logic [BSEL_W-1:0] byte_sel,
  output logic [7:0]        dout,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int TMAX  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W = $clog2(TMAX + 1);

  typedef logic [TMR_W-1:0] tmr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  localparam tmr_t SETTLE_LAST = tmr_t'(SETTLE_CYCLES - 1);
  localparam tmr_t GATE_LAST   = tmr_t'(GATE_CYCLES - 1);
  localparam cnt_t CNT_MAX     = '1;

  state_t            state, state_d;
  logic [NUM_CH-1:0] s1, s2, s3;
  logic [CH_W-1:0]   ch_q, ch_d;
  tmr_t              timer, timer_d;
  cnt_t              acc, acc_d, count_d;
  logic              acc_ovf, acc_ovf_d, overflow_d;
  logic              ring_edge;

  // Synchronizers and the edge-detect delay run even while frozen, so edges
  // that occur during a freeze are consumed rather than counted on resume.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its source, regardless of statement order.
      s1 <= ring_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ring_edge = s2[ch_q] & ~s3[ch_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch_q     <= '0;
      timer    <= '0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      ch_q     <= ch_d;
      timer    <= timer_d;
      acc      <= acc_d;
      acc_ovf  <= acc_ovf_d;
      count    <= count_d;
      overflow <= overflow_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold value first; any path that
    // skips an assignment would otherwise infer a latch.
    state_d    = state;
    ch_d       = ch_q;
    timer_d    = timer;
    acc_d      = acc;
    acc_ovf_d  = acc_ovf;
    count_d    = count;
    overflow_d = overflow;
    if (ena) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ch_d      = ch_sel;
            timer_d   = '0;
            acc_d     = '0;
            acc_ovf_d = 1'b0;
            state_d   = SETTLE;
          end
        end
        SETTLE: begin
          if (timer == SETTLE_LAST) begin
            timer_d = '0;
            state_d = MEASURE;
          end else begin
            timer_d = timer + tmr_t'(1);
          end
        end
        MEASURE: begin
          // Saturate instead of wrapping; a lost increment marks the result.
          if (ring_edge) begin
            if (acc == CNT_MAX) acc_ovf_d = 1'b1;
            else                acc_d     = acc + cnt_t'(1);
          end
          if (timer == GATE_LAST) begin
            count_d    = acc_d;
            overflow_d = acc_ovf_d;
            state_d    = DONE;
          end else begin
            timer_d = timer + tmr_t'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state == SETTLE) || (state == MEASURE);
  assign done = (state == DONE);

  always_comb begin
    dout = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (byte_sel == BSEL_W'(b)) dout = count[8*b +: 8];
    end
  end

endmodule
